rv32_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the rv32 core's decode/execute. Owns the fetch PC, issues

---
 rtl/rv32_fetch_unit_if.sv | 26 ++
 rtl/rv32_fetch_unit.sv | 133 +++++++++++++
 tb/tb_rv32_fetch_unit.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_unit_if.sv
// Fetch-unit handshake bundle: redirect from the core, imem request/response, and the
// {pc, instruction} stream to the core. master = fetch unit side, slave = core/memory side.
interface rv32_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_err
    );
endinterface

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch stage: credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional macro RV32_FETCH_ALIGN_CHECK_EN: misaligned redirects set a sticky error and halt fetch.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    rv32_fetch_unit_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             halt_q, halt_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      pc_mem_q   [FIFO_DEPTH];
    logic [31:0]      data_mem_q [FIFO_DEPTH];

    logic        req_valid;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;

    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

`ifdef RV32_FETCH_ALIGN_CHECK_EN
    assign redirect_bad = |bus.redirect_pc[1:0];
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign redirect_bad         = 1'b0;
`endif

    always_comb begin
        req_valid = !reset && !bus.redirect_valid && !halt_q &&
                    (({1'b0, count_q} + {1'b0, outst_q}) < CREDITS);
        req_fire  = req_valid && bus.imem_req_ready;
        pop       = (count_q != '0) && bus.inst_ready;
        push      = 1'b0;

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        halt_d     = halt_q;
        misalign_d = misalign_q;

        if (bus.redirect_valid) begin
            // No request fires this cycle; a response arriving now is retired and discarded,
            // everything still in flight becomes stale.
            outst_d    = outst_q - CNT_W'(bus.imem_rsp_valid);
            drop_d     = outst_q - CNT_W'(bus.imem_rsp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            halt_d     = redirect_bad;
            misalign_d = misalign_q | redirect_bad;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_VECTOR;
            rsp_pc_q   <= RESET_VECTOR;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            halt_q     <= halt_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            data_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst_pc        = pc_mem_q[rd_ptr_q];
    assign bus.inst_data      = data_mem_q[rd_ptr_q];
    assign bus.misalign_err   = misalign_q;
endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: in-order latency-programmable memory model plus a
// queue-based reference model of the fetch stage; honours RV32_FETCH_ALIGN_CHECK_EN.
module tb_rv32_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_fetch_unit_if bus ();

    rv32_fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    ent_t        mq[$];
    pend_t       memq[$];
    int          last_due;
    int          m_out, m_drop;
    logic [31:0] m_fetch, m_rsp;
    bit          m_halt, m_mis;

    bit          m_req_valid;
    logic [31:0] m_req_addr;
    bit          m_inst_valid;
    logic [31:0] m_inst_pc, m_inst_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic model_reset();
        mq.delete();
        memq.delete();
        m_out = 0; m_drop = 0; last_due = 0;
        m_fetch = RV; m_rsp = RV;
        m_halt = 0; m_mis = 0;
    endtask

    // Let inputs settle, then form the model's view of the current cycle.
    task automatic settle();
        #1;
        m_req_valid  = !reset && !bus.redirect_valid && !m_halt && ((mq.size() + m_out) < int'(DEPTH));
        m_req_addr   = m_fetch;
        m_inst_valid = (mq.size() != 0);
        if (m_inst_valid) begin
            m_inst_pc   = mq[0].pc;
            m_inst_data = mq[0].data;
        end
    endtask

    task automatic advance();
        bit          fire, pop, rsp;
        logic [31:0] tgt;
        int          d;
        fire = m_req_valid && bus.imem_req_ready;
        pop  = m_inst_valid && bus.inst_ready;
        rsp  = bus.imem_rsp_valid;
        if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq.push_back('{bus.imem_req_addr, d});
        end
        if (reset) begin
            model_reset();
        end else if (bus.redirect_valid) begin
            tgt = bus.redirect_pc;
            if (rsp) m_out--;
            m_drop = m_out;
            mq.delete();
`ifdef RV32_FETCH_ALIGN_CHECK_EN
            m_halt = (tgt[1:0] != 2'b00);
            if (m_halt) m_mis = 1;
`endif
            tgt[1:0] = 2'b00;
            m_fetch = tgt;
            m_rsp   = tgt;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rsp) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else begin
                    mq.push_back('{m_rsp, mem_word(m_rsp)});
                    m_rsp += 32'd4;
                end
            end
            if (fire) begin
                m_out++;
                m_fetch += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.inst_ready = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got req_valid=%b inst_valid=%b misalign=%b exp 0 0 0",
                     bus.imem_req_valid, bus.inst_valid, bus.misalign_err);
        end
        advance();
        reset = 1'b0;
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RV) begin
            errors++;
            $display("FAIL reset_first_req got valid=%b addr=%h exp 1 %h", bus.imem_req_valid, bus.imem_req_addr, RV);
        end
        advance();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int          delivered = 0;
        bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1; lat = 1;
        exp_pc = RV;
        for (int i = 0; i < 24; i++) begin
            settle();
            checks++;
            if (bus.imem_req_valid !== m_req_valid || (m_req_valid && bus.imem_req_addr !== m_req_addr)) begin
                errors++;
                $display("FAIL stream_req cyc=%0d got %b/%h exp %b/%h", cyc, bus.imem_req_valid, bus.imem_req_addr, m_req_valid, m_req_addr);
            end
            checks++;
            if (bus.inst_valid !== m_inst_valid) begin
                errors++;
                $display("FAIL stream_inst_valid cyc=%0d got %b exp %b", cyc, bus.inst_valid, m_inst_valid);
            end
            if (bus.inst_valid === 1'b1) begin
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL stream_order got pc=%h data=%h exp pc=%h data=%h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                delivered++;
            end
            advance();
        end
        checks++;
        if (delivered < 12) begin
            errors++;
            $display("FAIL stream_throughput got %0d instructions exp at least 12", delivered);
        end
    endtask

    task automatic test_backpressure();
        int          fires = 0;
        bit          got = 0;
        logic [31:0] got_addr = '0;
        reset = 1'b1;
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_req got %b exp 0", bus.imem_req_valid);
        end
        advance();
        reset = 1'b0; bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1; lat = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.imem_req_valid === 1'b1) fires++;
            advance();
        end
        settle();
        checks++;
        if (fires != int'(DEPTH) || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_credit got fires=%0d req_valid=%b inst_valid=%b exp %0d 0 1",
                     fires, bus.imem_req_valid, bus.inst_valid, DEPTH);
        end
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.imem_req_valid === 1'b1) begin
                got = 1; got_addr = bus.imem_req_addr;
                advance();
                break;
            end
            advance();
        end
        checks++;
        if (!got || got_addr !== RV + 32'(4 * DEPTH)) begin
            errors++;
            $display("FAIL backpressure_resume got resumed=%0d addr=%h exp 1 %h", got, got_addr, RV + 32'(4 * DEPTH));
        end
    endtask

    task automatic test_req_stall();
        reset = 1'b1; settle(); advance();
        reset = 1'b0; bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RV) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got %b/%h exp 1/%h", cyc, bus.imem_req_valid, bus.imem_req_addr, RV);
            end
            advance();
        end
        bus.imem_req_ready = 1'b1;
        settle();
        advance();
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RV + 32'd4) begin
            errors++;
            $display("FAIL stall_accept got %b/%h exp 1/%h", bus.imem_req_valid, bus.imem_req_addr, RV + 32'd4);
        end
        advance();
    endtask

    task automatic test_redirect_drop();
        bit got = 0;
        reset = 1'b1; settle(); advance();
        reset = 1'b0; lat = 3; bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
        settle(); advance();
        settle(); advance();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_req got %b exp 0", bus.imem_req_valid);
        end
        advance();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            settle();
            if (bus.inst_valid === 1'b1) begin
                got = 1;
                checks++;
                if (bus.inst_pc !== 32'h100 || bus.inst_data !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL redirect_drop got pc=%h data=%h exp pc=00000100 data=%h", bus.inst_pc, bus.inst_data, mem_word(32'h100));
                end
            end
            advance();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL redirect_drop_timeout got no instruction exp pc=00000100");
        end
    endtask

    task automatic test_redirect_handshake();
        bit          found = 0, got = 0;
        logic [31:0] taken_pc = '0;
        lat = 1; bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            settle();
            if (m_inst_valid && bus.imem_rsp_valid === 1'b1) begin
                found = 1;
                taken_pc = m_inst_pc;
                bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0300;
                settle();
                checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== taken_pc) begin
                    errors++;
                    $display("FAIL hs_redirect_take got %b/%h exp 1/%h", bus.inst_valid, bus.inst_pc, taken_pc);
                end
            end
            advance();
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hs_redirect_setup got no overlap of handshake and response exp one");
        end
        settle();
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL hs_redirect_flush got inst_valid=%b exp 0", bus.inst_valid);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            if (i != 0) settle();
            if (bus.inst_valid === 1'b1) begin
                got = 1;
                checks++;
                if (bus.inst_pc !== 32'h300) begin
                    errors++;
                    $display("FAIL hs_redirect_first got pc=%h exp 00000300", bus.inst_pc);
                end
            end
            advance();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL hs_redirect_timeout got no instruction exp pc=00000300");
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc = 32'hFFFF_FFF8;
        int          seen = 0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        settle(); advance();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 40 && seen < 4; i++) begin
            settle();
            if (bus.inst_valid === 1'b1) begin
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL wrap_order got pc=%h data=%h exp pc=%h data=%h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                seen++;
            end
            advance();
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL wrap_timeout got %0d instructions exp 4", seen);
        end
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
        settle(); advance();
        bus.redirect_valid = 1'b0;
`ifdef RV32_FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++;
            if (bus.misalign_err !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_halt cyc=%0d got err=%b req=%b exp 1 0", cyc, bus.misalign_err, bus.imem_req_valid);
            end
            advance();
        end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
        settle(); advance();
        bus.redirect_valid = 1'b0;
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200 || bus.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_resume got req=%b addr=%h err=%b exp 1 00000200 1", bus.imem_req_valid, bus.imem_req_addr, bus.misalign_err);
        end
        advance();
`else
        settle();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100 || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_forced got req=%b addr=%h err=%b exp 1 00000100 0", bus.imem_req_valid, bus.imem_req_addr, bus.misalign_err);
        end
        advance();
`endif
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 500; i++) begin
            reset              = ($urandom_range(0, 99) == 0);
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = ($urandom_range(0, 2) != 0);
            lat                = int'($urandom_range(1, 4));
            tgt                = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = tgt;
            settle();
            checks++;
            if (bus.imem_req_valid !== m_req_valid || (m_req_valid && bus.imem_req_addr !== m_req_addr)) begin
                errors++;
                $display("FAIL rand_req cyc=%0d got %b/%h exp %b/%h", cyc, bus.imem_req_valid, bus.imem_req_addr, m_req_valid, m_req_addr);
            end
            checks++;
            if (bus.inst_valid !== m_inst_valid ||
                (m_inst_valid && (bus.inst_pc !== m_inst_pc || bus.inst_data !== m_inst_data))) begin
                errors++;
                $display("FAIL rand_inst cyc=%0d got %b/%h/%h exp %b/%h/%h", cyc, bus.inst_valid, bus.inst_pc, bus.inst_data,
                         m_inst_valid, m_inst_pc, m_inst_data);
            end
            checks++;
            if (bus.misalign_err !== m_mis) begin
                errors++;
                $display("FAIL rand_misalign cyc=%0d got %b exp %b", cyc, bus.misalign_err, m_mis);
            end
            advance();
        end
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_drop();
        test_redirect_handshake();
        test_wrap();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
